// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram counter and next-address logic for the
// picoRISC control unit, with a small LIFO return stack for micro-calls.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   stall        hold upc, stack and stack_err this cycle
//   br_mode      0/7 NEXT, 1 JMP, 2 JC, 3 JNC, 4 DISPATCH, 5 CALL, 6 RET
//   cond_sel     condition index for JC/JNC
//   cond_vec     condition flags
//   br_target    branch target field of the current microinstruction
//   kmbr_addr    opcode dispatch address
//   kmbr_valid   dispatch address is valid
//   upc          current microinstruction address (registered)
//   illegal      one-cycle pulse after a DISPATCH with kmbr_valid=0
//   stack_err    sticky flag: CALL on full or RET on empty stack
module micro_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned COND_W      = 16,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0,
  parameter int unsigned TRAP_ADDR   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [2:0]        br_mode,
  input  logic [SEL_W-1:0]  cond_sel,
  input  logic [COND_W-1:0] cond_vec,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] kmbr_addr,
  input  logic              kmbr_valid,
  output logic [ADDR_W-1:0] upc,
  output logic              illegal,
  output logic              stack_err
);

  localparam int unsigned PTR_W    = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned COND_PAD = 2 ** SEL_W;

  localparam logic [2:0] M_JMP      = 3'd1;
  localparam logic [2:0] M_JC       = 3'd2;
  localparam logic [2:0] M_JNC      = 3'd3;
  localparam logic [2:0] M_DISPATCH = 3'd4;
  localparam logic [2:0] M_CALL     = 3'd5;
  localparam logic [2:0] M_RET      = 3'd6;

  logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0]    sp;

  logic [ADDR_W-1:0]   inc;
  logic [COND_PAD-1:0] cond_pad;
  logic                cond_hit;
  logic                stack_full;
  logic                stack_empty;
  logic [ADDR_W-1:0]   tos;

  logic [ADDR_W-1:0]   upc_nxt;
  logic                push;
  logic                pop;
  logic                err_set;
  logic                illegal_nxt;

  // Zero-padding makes out-of-range selects read as false.
  assign cond_pad    = COND_PAD'(cond_vec);
  assign cond_hit    = cond_pad[cond_sel];
  assign inc         = upc + ADDR_W'(1);
  assign stack_full  = (sp == CNT_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign tos         = stack_mem[PTR_W'(sp - CNT_W'(1))];

  // Next-address selection for an unstalled cycle.
  always_comb begin
    upc_nxt     = inc;
    push        = 1'b0;
    pop         = 1'b0;
    err_set     = 1'b0;
    illegal_nxt = 1'b0;
    unique case (br_mode)
      M_JMP: upc_nxt = br_target;
      M_JC:  upc_nxt = cond_hit ? br_target : inc;
      M_JNC: upc_nxt = cond_hit ? inc : br_target;
      M_DISPATCH: begin
        if (kmbr_valid) begin
          upc_nxt = kmbr_addr;
        end else begin
          upc_nxt     = ADDR_W'(TRAP_ADDR);
          illegal_nxt = 1'b1;
        end
      end
      M_CALL: begin
        if (!stack_full) begin
          upc_nxt = br_target;
          push    = 1'b1;
        end else begin
          upc_nxt = ADDR_W'(TRAP_ADDR);
          err_set = 1'b1;
        end
      end
      M_RET: begin
        if (!stack_empty) begin
          upc_nxt = tos;
          pop     = 1'b1;
        end else begin
          upc_nxt = ADDR_W'(TRAP_ADDR);
          err_set = 1'b1;
        end
      end
      default: upc_nxt = inc;
    endcase
  end

  // uPC, stack pointer and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upc       <= ADDR_W'(RESET_ADDR);
      sp        <= '0;
      illegal   <= 1'b0;
      stack_err <= 1'b0;
    end else if (stall) begin
      illegal <= 1'b0;
    end else begin
      upc     <= upc_nxt;
      illegal <= illegal_nxt;
      if (err_set) stack_err <= 1'b1;
      if (push) sp <= sp + CNT_W'(1);
      else if (pop) sp <= sp - CNT_W'(1);
    end
  end

  // Return-address storage; contents are only meaningful below sp.
  always_ff @(posedge clk) begin
    if (rst_n && !stall && push) begin
      stack_mem[PTR_W'(sp)] <= inc;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [2:0]  br_mode;
  logic [3:0]  cond_sel;
  logic [15:0] cond_vec;
  logic [7:0]  br_target;
  logic [7:0]  kmbr_addr;
  logic        kmbr_valid;
  logic [7:0]  upc;
  logic        illegal;
  logic        stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int unsigned m_upc = 0;
  int unsigned m_stk[$];
  bit          m_err = 0;
  bit          m_ill = 0;

  micro_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_mode   (br_mode),
    .cond_sel  (cond_sel),
    .cond_vec  (cond_vec),
    .br_target (br_target),
    .kmbr_addr (kmbr_addr),
    .kmbr_valid(kmbr_valid),
    .upc       (upc),
    .illegal   (illegal),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural next-state from the sampled inputs.
  task automatic model_update();
    int unsigned inc;
    bit c;
    if (!rst_n) begin
      m_upc = 0;
      m_stk.delete();
      m_err = 0;
      m_ill = 0;
    end else if (stall) begin
      m_ill = 0;
    end else begin
      m_ill = 0;
      inc = (m_upc + 1) % 256;
      c = (int'(cond_sel) < 16) ? cond_vec[cond_sel] : 1'b0;
      case (br_mode)
        3'd1: m_upc = br_target;
        3'd2: m_upc = c ? br_target : inc;
        3'd3: m_upc = c ? inc : br_target;
        3'd4: begin
          if (kmbr_valid) m_upc = kmbr_addr;
          else begin m_upc = 255; m_ill = 1; end
        end
        3'd5: begin
          if (m_stk.size() < 4) begin
            m_stk.push_back(inc);
            m_upc = br_target;
          end else begin
            m_upc = 255; m_err = 1;
          end
        end
        3'd6: begin
          if (m_stk.size() > 0) m_upc = m_stk.pop_back();
          else begin m_upc = 255; m_err = 1; end
        end
        default: m_upc = inc;
      endcase
    end
  endtask

  // One clock: advance model, then compare all outputs just after the edge.
  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check("upc", upc, m_upc);
    check("illegal", illegal, m_ill);
    check("stack_err", stack_err, m_err);
  endtask

  task automatic op(input logic [2:0] mode, input logic [7:0] tgt);
    rst_n     = 1'b1;
    stall     = 1'b0;
    br_mode   = mode;
    br_target = tgt;
    cyc();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    stall   = 1'b0;
    br_mode = 3'd0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_mode = 3'd0; cond_sel = '0; cond_vec = '0;
    br_target = '0; kmbr_addr = '0; kmbr_valid = 1'b0;

    // Reset state, then free-running NEXT with wrap.
    do_reset();
    check("reset_upc", upc, 0);
    for (int i = 0; i < 300; i++) begin
      op(3'((i % 2 == 0) ? 0 : 7), 8'h00);
      check("next_seq", upc, (i + 1) % 256);
    end

    // Dispatch valid and invalid.
    kmbr_addr = 8'd41; kmbr_valid = 1'b1;
    op(3'd4, 8'h00);
    check("dispatch_ok", upc, 41);
    kmbr_valid = 1'b0;
    op(3'd4, 8'h00);
    check("dispatch_trap", upc, 255);
    check("illegal_pulse", illegal, 1);
    op(3'd0, 8'h00);
    check("illegal_clear", illegal, 0);

    // Conditional jumps on cond_vec[3].
    cond_sel = 4'd3;
    cond_vec = 16'h0008;
    op(3'd2, 8'h20);
    check("jc_taken", upc, 8'h20);
    cond_vec = 16'hfff7;
    op(3'd2, 8'h60);
    check("jc_not_taken", upc, 8'h21);
    op(3'd3, 8'h60);
    check("jnc_taken", upc, 8'h60);
    cond_vec = 16'h0008;
    op(3'd3, 8'h20);
    check("jnc_not_taken", upc, 8'h61);

    // Nested call/return.
    do_reset();
    op(3'd1, 8'd10);
    op(3'd5, 8'h30);
    check("call1", upc, 8'h30);
    op(3'd5, 8'h50);
    check("call2", upc, 8'h50);
    op(3'd6, 8'h00);
    check("ret1", upc, 8'h31);
    op(3'd6, 8'h00);
    check("ret2", upc, 8'd11);
    op(3'd6, 8'h00);
    check("ret_empty", upc, 255);

    // Stack overflow and underflow.
    do_reset();
    for (int i = 0; i < 4; i++) op(3'd5, 8'h10);
    check("no_err_at_full", stack_err, 0);
    op(3'd5, 8'h10);
    check("overflow_upc", upc, 255);
    check("overflow_err", stack_err, 1);
    do_reset();
    check("err_cleared", stack_err, 0);
    op(3'd6, 8'h00);
    check("underflow_upc", upc, 255);
    op(3'd0, 8'h00);
    op(3'd1, 8'h05);
    check("err_sticky", stack_err, 1);

    // Stall during JMP, then reset mid-stall.
    do_reset();
    op(3'd0, 8'h00);
    stall = 1'b1; br_mode = 3'd1; br_target = 8'h40;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_hold", upc, 1);
    end
    op(3'd1, 8'h40);
    check("after_stall", upc, 8'h40);
    op(3'd5, 8'h70);
    stall = 1'b1;
    cyc();
    rst_n = 1'b0;
    cyc();
    check("reset_in_stall", upc, 0);
    op(3'd6, 8'h00);
    check("stack_empty_after_rst", upc, 255);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      stall      = ($urandom_range(0, 7) == 0);
      br_mode    = 3'($urandom_range(0, 7));
      cond_sel   = 4'($urandom);
      cond_vec   = 16'($urandom);
      br_target  = 8'($urandom);
      kmbr_addr  = 8'($urandom);
      kmbr_valid = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
